// File: rtl/cfa_pkg.sv
// -----------------------------------------------------------------------------
// cfa_pkg
// Shared definitions for the 5x5 CFA window builder:
//   - default image geometry and pixel width
//   - FSM state encoding
//   - win_idx(R,C): slot number of window element eRtC in the flattened bus
//     (1-based row/column, row 1 = oldest line, column 1 = leftmost)
// -----------------------------------------------------------------------------
package cfa_pkg;

  localparam int DATA_W = 12;
  localparam int IMG_W  = 640;
  localparam int IMG_H  = 480;
  localparam int COL_W  = 10;
  localparam int ROW_W  = 9;

  localparam int WIN_N  = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Element eRtC lives at win_out[win_idx(R,C)*DATA_W +: DATA_W].
  function automatic int win_idx(input int r, input int c);
    return (r - 1) * WIN_N + (c - 1);
  endfunction

endpackage

// File: rtl/cfa_line_buffer.sv
// -----------------------------------------------------------------------------
// cfa_line_buffer
// One image line of CFA pixels, addressed by column.
// Synchronous write, asynchronous read. A write and a read to the same
// address in the same cycle return the old contents, which is what lets the
// four buffers be chained into a vertical shift register.
//
// Ports:
//   clk      in   rising-edge clock
//   we_i     in   write enable
//   addr_i   in   column address (read and write)
//   wdata_i  in   pixel written at addr_i on the clock edge
//   rdata_o  out  current contents at addr_i
// -----------------------------------------------------------------------------
module cfa_line_buffer #(
  parameter int DEPTH  = 640,
  parameter int DATA_W = 12,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: the storage array has no reset; it maps to RAM, and row gating in
  // the parent keeps any stale line contents from ever being flagged valid.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/cfa_window_5x5.sv
// -----------------------------------------------------------------------------
// cfa_window_5x5
// Builds a sliding 5x5 Bayer neighbourhood from a raster-order CFA stream,
// one pixel in and one window out per accepted pixel, 1-cycle latency.
// Four chained line buffers provide the four previous lines at the current
// column; a 5x5 register array shifts left on each accepted pixel and loads
// the new column on the right. Only windows lying fully inside the image are
// flagged valid (row >= 4 and col >= 4 at the accepted pixel).
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   start       in   one-cycle pulse that arms a new frame (sampled in IDLE)
//   pix_in      in   CFA pixel, raster order
//   pix_valid   in   pix_in valid this cycle (accepted only while ACTIVE)
//   win_out     out  flattened window, eRtC at win_idx(R,C)*DATA_W
//   win_valid   out  win_out holds a full, valid window
//   busy        out  frame in progress
//   frame_done  out  one-cycle pulse after the last frame pixel is accepted
// -----------------------------------------------------------------------------
module cfa_window_5x5 #(
  parameter int DATA_W = cfa_pkg::DATA_W,
  parameter int IMG_W  = cfa_pkg::IMG_W,
  parameter int IMG_H  = cfa_pkg::IMG_H,
  parameter int COL_W  = cfa_pkg::COL_W,
  parameter int ROW_W  = cfa_pkg::ROW_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_W-1:0]   pix_in,
  input  logic                pix_valid,
  output logic [25*DATA_W-1:0] win_out,
  output logic                win_valid,
  output logic                busy,
  output logic                frame_done
);

  import cfa_pkg::*;

  localparam int               LB_AW     = $clog2(IMG_W);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(4);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(4);

  state_e             state_q;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [DATA_W-1:0]  win_q [5][5];   // [row-1][col-1]
  logic               win_valid_q;
  logic               busy_q;
  logic               frame_done_q;

  logic               accept;
  logic               last_pix;
  logic               win_hit;

  logic [DATA_W-1:0]  lb_rd [4];
  logic [DATA_W-1:0]  lb_wd [4];

  assign accept = (state_q == ACTIVE) && pix_valid;

  // ---------------------------------------------------------------------------
  // Line buffers: LB0 holds the previous line, LB3 the line four rows up.
  // Each write pushes the column one line deeper.
  // ---------------------------------------------------------------------------
  assign lb_wd[0] = pix_in;

  for (genvar k = 1; k < 4; k++) begin : g_lb_chain
    assign lb_wd[k] = lb_rd[k-1];
  end

  for (genvar k = 0; k < 4; k++) begin : g_lb
    cfa_line_buffer #(
      .DEPTH  (IMG_W),
      .DATA_W (DATA_W)
    ) u_lb (
      .clk     (clk),
      .we_i    (accept),
      .addr_i  (col_q[LB_AW-1:0]),
      .wdata_i (lb_wd[k]),
      .rdata_o (lb_rd[k])
    );
  end

  // ---------------------------------------------------------------------------
  // Raster position of the pixel being accepted this cycle.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  assign last_pix = accept && (col_q == COL_LAST) && (row_q == ROW_LAST);
  // Windows before column 4 straddle a line wrap; before row 4 they reach
  // above the frame. Neither is flagged.
  assign win_hit  = accept && (col_q >= COL_FIRST) && (row_q >= ROW_FIRST);

  // ---------------------------------------------------------------------------
  // Control FSM, counters and window array.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, making the shift below order-independent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      frame_done_q <= 1'b0;
      win_valid_q  <= win_hit;

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ACTIVE;
            busy_q  <= 1'b1;
            col_q   <= '0;
            row_q   <= '0;
          end
        end
        ACTIVE: begin
          col_q <= col_d;
          row_q <= row_d;
          if (last_pix) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
            col_q        <= '0;
            row_q        <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      if (accept) begin
        for (int r = 0; r < 5; r++) begin
          for (int c = 0; c < 4; c++) begin
            win_q[r][c] <= win_q[r][c+1];
          end
        end
        // New right-hand column: oldest line at the top, live pixel at bottom.
        win_q[0][4] <= lb_rd[3];
        win_q[1][4] <= lb_rd[2];
        win_q[2][4] <= lb_rd[1];
        win_q[3][4] <= lb_rd[0];
        win_q[4][4] <= pix_in;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  for (genvar r = 1; r <= 5; r++) begin : g_row
    for (genvar c = 1; c <= 5; c++) begin : g_col
      assign win_out[win_idx(r, c)*DATA_W +: DATA_W] = win_q[r-1][c-1];
    end
  end

  assign win_valid  = win_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_cfa_window_5x5.sv
// -----------------------------------------------------------------------------
// tb_cfa_window_5x5
// Self-checking bench for cfa_window_5x5 on an 8x6 image.
// A table of frame scenarios drives whole frames; every expected window is
// built from the bench's own image function and queued when its last pixel is
// driven, then popped when the DUT raises win_valid.
// -----------------------------------------------------------------------------
module tb_cfa_window_5x5;

  localparam int DW    = 12;
  localparam int W     = 8;
  localparam int H     = 6;
  localparam int WIN_W = 25 * DW;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [DW-1:0]    pix_in;
  logic             pix_valid;
  logic [WIN_W-1:0] win_out;
  logic             win_valid;
  logic             busy;
  logic             frame_done;

  cfa_window_5x5 #(
    .DATA_W (DW),
    .IMG_W  (W),
    .IMG_H  (H),
    .COL_W  (4),
    .ROW_W  (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .win_out    (win_out),
    .win_valid  (win_valid),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode;        // 0: r*16+c, 1: +100, 2: 255-(r*16+c)
    int stall;       // pix_valid low every other cycle
    int start_mid;   // stray start pulse during the frame
    int abort_first; // reset at pixel (3,2) before the real frame
    int f11, f33, f55;   // first window e1t1, e3t3, e5t5
    int w5_11, w5_55;    // fifth window (pixel (5,4)) e1t1, e5t5
    int l55;             // last window e5t5
    int count;           // windows per frame
  } frame_vec_t;

  frame_vec_t       tbl [4];
  logic [WIN_W-1:0] sb_q [$];

  int               checks   = 0;
  int               failures = 0;
  int               n_win;
  logic [WIN_W-1:0] first_act, fifth_act, last_act;
  logic [WIN_W-1:0] last_exp;
  logic             hold_armed;

  task automatic check(input string name, input logic [WIN_W-1:0] act,
                       input logic [WIN_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int mode, input int r, input int c);
    int v;
    case (mode)
      1:       v = r * 16 + c + 100;
      2:       v = 255 - (r * 16 + c);
      default: v = r * 16 + c;
    endcase
    return DW'(v);
  endfunction

  // Window whose newest pixel is (r,c): eRtC = image(r-5+R, c-5+C).
  function automatic logic [WIN_W-1:0] exp_window(input int mode, input int r, input int c);
    logic [WIN_W-1:0] w;
    w = '0;
    for (int rr = 1; rr <= 5; rr++) begin
      for (int cc = 1; cc <= 5; cc++) begin
        w[((rr-1)*5 + (cc-1))*DW +: DW] = pix(mode, r - 5 + rr, c - 5 + cc);
      end
    end
    return w;
  endfunction

  function automatic int elem(input logic [WIN_W-1:0] w, input int r, input int c);
    return int'(w[((r-1)*5 + (c-1))*DW +: DW]);
  endfunction

  // One clock: drive at the falling edge, let the rising edge act, sample at
  // the next falling edge.
  task automatic step(input logic v, input logic st, input logic [DW-1:0] p,
                      input logic exp_v);
    start     = st;
    pix_valid = v;
    pix_in    = p;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    pix_valid = 1'b0;
    check("win_valid", WIN_W'(win_valid), WIN_W'(exp_v));
    if (!v && hold_armed) begin
      check("win_out_hold", win_out, last_exp);
    end
    if (win_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_window", WIN_W'(1), WIN_W'(0));
      end else begin
        check("window", win_out, sb_q.pop_front());
      end
      n_win++;
      if (n_win == 1) first_act = win_out;
      if (n_win == 5) fifth_act = win_out;
      last_act = win_out;
    end
    hold_armed = exp_v;
  endtask

  task automatic run_frame(input frame_vec_t t);
    logic ev;
    step(1'b0, 1'b1, '0, 1'b0);
    check("busy_after_start", WIN_W'(busy), WIN_W'(1));
    check("frame_done_low", WIN_W'(frame_done), WIN_W'(0));
    n_win = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (t.stall != 0) begin
          step(1'b0, 1'b0, DW'(12'hFFF), 1'b0);
        end
        ev = (r >= 4) && (c >= 4);
        if (ev) begin
          last_exp = exp_window(t.mode, r, c);
          sb_q.push_back(last_exp);
        end
        step(1'b1, (t.start_mid != 0) && (r == 2) && (c == 3), pix(t.mode, r, c), ev);
        if (r == H - 1 && c == W - 1) begin
          check("frame_done_pulse", WIN_W'(frame_done), WIN_W'(1));
          check("busy_after_frame", WIN_W'(busy), WIN_W'(0));
        end
      end
    end
    check("window_count", WIN_W'(n_win), WIN_W'(t.count));
    check("scoreboard_empty", WIN_W'(sb_q.size()), WIN_W'(0));
    check("first_e1t1", WIN_W'(elem(first_act, 1, 1)), WIN_W'(t.f11));
    check("first_e3t3", WIN_W'(elem(first_act, 3, 3)), WIN_W'(t.f33));
    check("first_e5t5", WIN_W'(elem(first_act, 5, 5)), WIN_W'(t.f55));
    check("wrap_e1t1",  WIN_W'(elem(fifth_act, 1, 1)), WIN_W'(t.w5_11));
    check("wrap_e5t5",  WIN_W'(elem(fifth_act, 5, 5)), WIN_W'(t.w5_55));
    check("last_e5t5",  WIN_W'(elem(last_act, 5, 5)),  WIN_W'(t.l55));
  endtask

  // Start a frame, stop it with reset at pixel (3,2), and confirm IDLE.
  task automatic abort_frame();
    step(1'b0, 1'b1, '0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r < 3 || c <= 2) step(1'b1, 1'b0, pix(0, r, c), 1'b0);
      end
    end
    rst = 1'b0;
    #1;
    check("abort_busy",       WIN_W'(busy),       WIN_W'(0));
    check("abort_win_valid",  WIN_W'(win_valid),  WIN_W'(0));
    check("abort_frame_done", WIN_W'(frame_done), WIN_W'(0));
    check("abort_win_out",    win_out,            '0);
    @(negedge clk);
    rst = 1'b1;
    // Without a new start the stream must stay ignored.
    step(1'b1, 1'b0, DW'(12'h5A5), 1'b0);
    step(1'b1, 1'b0, DW'(12'h5A6), 1'b0);
    check("abort_idle_busy", WIN_W'(busy), WIN_W'(0));
    check("abort_sb_empty",  WIN_W'(sb_q.size()), WIN_W'(0));
  endtask

  initial begin
    //          mode stall smid abort f11  f33  f55  w511 w555 l55 cnt
    tbl[0] = '{0,   0,    0,   0,    0,   34,  68,  16,  84,  87, 8};
    tbl[1] = '{0,   1,    1,   0,    0,   34,  68,  16,  84,  87, 8};
    tbl[2] = '{1,   0,    0,   1,    100, 134, 168, 116, 184, 187, 8};
    tbl[3] = '{2,   0,    0,   0,    255, 221, 187, 239, 171, 168, 8};

    hold_armed = 1'b0;
    last_exp   = '0;
    n_win      = 0;
    rst        = 1'b0;
    start      = 1'b0;
    pix_valid  = 1'b0;
    pix_in     = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",       WIN_W'(busy),       WIN_W'(0));
    check("reset_win_valid",  WIN_W'(win_valid),  WIN_W'(0));
    check("reset_frame_done", WIN_W'(frame_done), WIN_W'(0));
    check("reset_win_out",    win_out,            '0);
    rst = 1'b1;
    @(negedge clk);

    // pix_valid before start must not move the counters.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, DW'(12'h300 + i), 1'b0);
    end
    check("idle_busy", WIN_W'(busy), WIN_W'(0));

    for (int i = 0; i < 4; i++) begin
      if (tbl[i].abort_first != 0) abort_frame();
      run_frame(tbl[i]);
    end

    step(1'b0, 1'b0, '0, 1'b0);
    check("end_frame_done_low", WIN_W'(frame_done), WIN_W'(0));
    check("end_busy_low",       WIN_W'(busy),       WIN_W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
